// File: rtl/osd_dii_demux.sv
// DII packet demultiplexer: steers each whole packet to one of PORTS outputs by the
// destination ID in its header flit; out-of-window packets are dropped or sent to port 0.
package osd_dii_pkg;
    typedef struct packed {
        logic [15:0] data;
        logic        last;
        logic        valid;
    } dii_flit;
endpackage

module osd_dii_demux
    import osd_dii_pkg::*;
#(
    parameter int unsigned PORTS        = 2,
    parameter logic [15:0] BASE_ID      = 16'h0000,
    parameter bit          DROP_UNKNOWN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  dii_flit          dii_in,
    output logic             dii_in_ready,
    output dii_flit          dii_out [PORTS],
    input  logic [PORTS-1:0] dii_out_ready,
    output logic [15:0]      drop_count,
    output logic [1:0]       dbg_state
);

    localparam int unsigned SEL_W = $clog2(PORTS);

    if (PORTS < 2 || PORTS > 16) begin : g_bad_ports
        $error("osd_dii_demux: PORTS must be within 2..16");
    end
    if (32'(BASE_ID) + PORTS - 1 > 32'h0000_FFFF) begin : g_bad_window
        $error("osd_dii_demux: BASE_ID + PORTS - 1 exceeds 16'hFFFF");
    end

    // Handshake: a flit moves on any interface in a cycle where valid & ready are
    // both high; a valid flit keeps its data stable until it is taken.

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_FWD  = 2'd2,
        ST_DROP = 2'd3
    } state_t;

    state_t           state_q, state_d;
    dii_flit          hdr_q, hdr_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [15:0]      drop_q, drop_d;

    logic [15:0]      offset;
    logic             in_window;
    logic             route_hdr;
    logic [SEL_W-1:0] hdr_sel;
    logic             ready_raw;
    logic             accept;

    // Unsigned compare first so a dest below BASE_ID never wraps into the window.
    always_comb begin
        offset    = dii_in.data - BASE_ID;
        in_window = (dii_in.data >= BASE_ID) && (offset < 16'(PORTS));
        route_hdr = in_window || !DROP_UNKNOWN;
        hdr_sel   = in_window ? offset[SEL_W-1:0] : '0;
    end

    always_comb begin
        ready_raw = 1'b0;
        case (state_q)
            ST_IDLE: ready_raw = 1'b1;
            ST_HDR:  ready_raw = 1'b0;
            ST_FWD:  ready_raw = dii_out_ready[sel_q];
            ST_DROP: ready_raw = 1'b1;
            default: ready_raw = 1'b0;
        endcase
        dii_in_ready = rst & ready_raw;
        accept       = dii_in.valid & dii_in_ready;
    end

    always_comb begin
        state_d = state_q;
        hdr_d   = hdr_q;
        sel_d   = sel_q;
        drop_d  = drop_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    hdr_d = dii_in;
                    sel_d = hdr_sel;
                    if (route_hdr) begin
                        state_d = ST_HDR;
                    end else begin
                        if (drop_q != 16'hFFFF) begin
                            drop_d = drop_q + 16'd1;
                        end
                        state_d = dii_in.last ? ST_IDLE : ST_DROP;
                    end
                end
            end
            ST_HDR: begin
                if (dii_out_ready[sel_q]) begin
                    state_d = hdr_q.last ? ST_IDLE : ST_FWD;
                end
            end
            ST_FWD, ST_DROP: begin
                if (accept && dii_in.last) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Body flits bypass all registers; only the header is replayed from hdr_q.
    always_comb begin
        for (int p = 0; p < PORTS; p++) begin
            dii_out[p] = '0;
            if (sel_q == SEL_W'(p)) begin
                if (state_q == ST_HDR) begin
                    dii_out[p]       = hdr_q;
                    dii_out[p].valid = 1'b1;
                end else if (state_q == ST_FWD) begin
                    dii_out[p] = dii_in;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            hdr_q   <= '0;
            sel_q   <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            hdr_q   <= hdr_d;
            sel_q   <= sel_d;
            drop_q  <= drop_d;
        end
    end

    assign drop_count = drop_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_osd_dii_demux.sv
// Directed bench for osd_dii_demux: routing, drop/saturation, fallback to port 0,
// backpressure and asynchronous mid-packet reset.
module tb_osd_dii_demux;
    import osd_dii_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   tests = 0;
    int   fails = 0;

    dii_flit     a_in;
    logic        a_in_ready;
    dii_flit     a_out [2];
    logic [1:0]  a_out_ready;
    logic [15:0] a_drop;
    logic [1:0]  a_state;

    dii_flit     b_in;
    logic        b_in_ready;
    dii_flit     b_out [4];
    logic [3:0]  b_out_ready;
    logic [15:0] b_drop;
    logic [1:0]  b_state;

    logic [15:0] bp_data [3];
    int          k;
    logic        r;

    osd_dii_demux #(.PORTS(2), .BASE_ID(16'h0010), .DROP_UNKNOWN(1'b1)) u_a (
        .clk(clk), .rst(rst), .dii_in(a_in), .dii_in_ready(a_in_ready),
        .dii_out(a_out), .dii_out_ready(a_out_ready), .drop_count(a_drop),
        .dbg_state(a_state)
    );

    osd_dii_demux #(.PORTS(4), .BASE_ID(16'h0010), .DROP_UNKNOWN(1'b0)) u_b (
        .clk(clk), .rst(rst), .dii_in(b_in), .dii_in_ready(b_in_ready),
        .dii_out(b_out), .dii_out_ready(b_out_ready), .drop_count(b_drop),
        .dbg_state(b_state)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    function automatic dii_flit mk(input logic [15:0] d, input logic l, input logic v);
        dii_flit f;
        f.data  = d;
        f.last  = l;
        f.valid = v;
        return f;
    endfunction

    task automatic chkf(input string tag, input dii_flit obs, input dii_flit exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        a_in        = '0;
        b_in        = '0;
        a_out_ready = 2'b11;
        b_out_ready = 4'b1111;
        bp_data[0]  = 16'hDDDD;
        bp_data[1]  = 16'hEEEE;
        bp_data[2]  = 16'hFFFF;

        // Held in reset
        #7;
        chkw("rst_ready", 32'(a_in_ready), 32'd0);
        chkw("rst_v0", 32'(a_out[0].valid), 32'd0);
        chkw("rst_v1", 32'(a_out[1].valid), 32'd0);
        chkw("rst_drop", 32'(a_drop), 32'd0);
        chkw("rst_state", 32'(a_state), 32'd0);
        #10;
        rst = 1'b1;
        tick();
        chkw("post_rst_ready", 32'(a_in_ready), 32'd1);

        // 3-flit packet to port 1
        a_in = mk(16'h0011, 1'b0, 1'b1);
        #1;
        chkw("idle_v1", 32'(a_out[1].valid), 32'd0);
        tick();
        a_in = mk(16'hAAAA, 1'b0, 1'b1);
        #1;
        chkf("p1_hdr", a_out[1], mk(16'h0011, 1'b0, 1'b1));
        chkw("p1_hdr_v0", 32'(a_out[0].valid), 32'd0);
        chkw("p1_hdr_rdy", 32'(a_in_ready), 32'd0);
        chkw("p1_hdr_state", 32'(a_state), 32'd1);
        tick();
        #1;
        chkf("p1_aaaa", a_out[1], mk(16'hAAAA, 1'b0, 1'b1));
        chkw("p1_fwd_rdy", 32'(a_in_ready), 32'd1);
        tick();
        a_in = mk(16'hBBBB, 1'b1, 1'b1);
        #1;
        chkf("p1_bbbb", a_out[1], mk(16'hBBBB, 1'b1, 1'b1));
        chkw("p1_fwd_v0", 32'(a_out[0].valid), 32'd0);
        tick();

        // Single-flit packet to port 0, header accepted 4 cycles after the previous one
        a_in = mk(16'h0010, 1'b1, 1'b1);
        #1;
        chkw("p2_accept_state", 32'(a_state), 32'd0);
        chkw("p2_accept_rdy", 32'(a_in_ready), 32'd1);
        tick();
        a_in = '0;
        #1;
        chkf("p2_hdr", a_out[0], mk(16'h0010, 1'b1, 1'b1));
        chkw("p2_hdr_v1", 32'(a_out[1].valid), 32'd0);
        tick();
        chkw("p2_idle", 32'(a_state), 32'd0);
        chkw("p2_v0", 32'(a_out[0].valid), 32'd0);
        chkw("p2_drop", 32'(a_drop), 32'd0);

        // Dropped 4-flit packet to 0005, then 2-flit packet to port 0
        a_in = mk(16'h0005, 1'b0, 1'b1);
        tick();
        a_in = mk(16'h1111, 1'b0, 1'b1);
        #1;
        chkw("drop_state", 32'(a_state), 32'd3);
        chkw("drop_cnt1", 32'(a_drop), 32'd1);
        chkw("drop_rdy", 32'(a_in_ready), 32'd1);
        chkw("drop_v0", 32'(a_out[0].valid), 32'd0);
        chkw("drop_v1", 32'(a_out[1].valid), 32'd0);
        tick();
        a_in = mk(16'h2222, 1'b0, 1'b1);
        tick();
        a_in = mk(16'h3333, 1'b1, 1'b1);
        #1;
        chkw("drop_last_v0", 32'(a_out[0].valid), 32'd0);
        chkw("drop_last_v1", 32'(a_out[1].valid), 32'd0);
        tick();
        a_in = mk(16'h0010, 1'b0, 1'b1);
        #1;
        chkw("after_drop_idle", 32'(a_state), 32'd0);
        tick();
        a_in = mk(16'hCCCC, 1'b1, 1'b1);
        #1;
        chkf("p3_hdr", a_out[0], mk(16'h0010, 1'b0, 1'b1));
        chkw("p3_hdr_v1", 32'(a_out[1].valid), 32'd0);
        tick();
        #1;
        chkf("p3_cccc", a_out[0], mk(16'hCCCC, 1'b1, 1'b1));
        tick();
        a_in = '0;
        #1;
        chkw("p3_idle", 32'(a_state), 32'd0);
        chkw("p3_drop", 32'(a_drop), 32'd1);

        // Backpressure on port 1 during HDR, then toggling during FWD
        a_in = mk(16'h0011, 1'b0, 1'b1);
        tick();
        a_out_ready[1] = 1'b0;
        a_in = mk(bp_data[0], 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            #1;
            chkf("bp_hdr_hold", a_out[1], mk(16'h0011, 1'b0, 1'b1));
            chkw("bp_hdr_rdy", 32'(a_in_ready), 32'd0);
            tick();
        end
        a_out_ready[1] = 1'b1;
        #1;
        chkf("bp_hdr_rel", a_out[1], mk(16'h0011, 1'b0, 1'b1));
        tick();
        k = 0;
        r = 1'b0;
        for (int cyc = 0; cyc < 12 && k < 3; cyc++) begin
            a_out_ready[1] = r;
            a_in = mk(bp_data[k], (k == 2), 1'b1);
            #1;
            chkf("bp_fwd_data", a_out[1], mk(bp_data[k], (k == 2), 1'b1));
            chkw("bp_fwd_rdy", 32'(a_in_ready), 32'(r));
            chkw("bp_fwd_v0", 32'(a_out[0].valid), 32'd0);
            tick();
            if (r) k++;
            r = ~r;
        end
        a_in = '0;
        a_out_ready[1] = 1'b1;
        #1;
        chkw("bp_flits", 32'(k), 32'd3);
        chkw("bp_idle", 32'(a_state), 32'd0);

        // Asynchronous reset mid-packet
        a_in = mk(16'h0011, 1'b0, 1'b1);
        tick();
        a_in = mk(16'h4444, 1'b0, 1'b1);
        tick();
        tick();
        a_in = mk(16'h5555, 1'b0, 1'b1);
        #1;
        chkf("mid_fwd", a_out[1], mk(16'h5555, 1'b0, 1'b1));
        #2;
        rst = 1'b0;
        #1;
        chkw("arst_v1", 32'(a_out[1].valid), 32'd0);
        chkw("arst_v0", 32'(a_out[0].valid), 32'd0);
        chkw("arst_rdy", 32'(a_in_ready), 32'd0);
        chkw("arst_state", 32'(a_state), 32'd0);
        chkw("arst_drop", 32'(a_drop), 32'd0);
        a_in = '0;
        @(posedge clk);
        #3;
        rst = 1'b1;
        tick();
        chkw("arst_rel_rdy", 32'(a_in_ready), 32'd1);
        a_in = mk(16'h0010, 1'b0, 1'b1);
        tick();
        a_in = mk(16'h7777, 1'b1, 1'b1);
        #1;
        chkf("arst_p_hdr", a_out[0], mk(16'h0010, 1'b0, 1'b1));
        tick();
        #1;
        chkf("arst_p_body", a_out[0], mk(16'h7777, 1'b1, 1'b1));
        tick();
        a_in = '0;
        #1;
        chkw("arst_p_idle", 32'(a_state), 32'd0);

        // Fallback routing (DROP_UNKNOWN=0, PORTS=4)
        b_in = mk(16'h0005, 1'b0, 1'b1);
        tick();
        b_in = mk(16'h9999, 1'b1, 1'b1);
        #1;
        chkf("fb_hdr", b_out[0], mk(16'h0005, 1'b0, 1'b1));
        chkw("fb_state", 32'(b_state), 32'd1);
        chkw("fb_v3", 32'(b_out[3].valid), 32'd0);
        tick();
        #1;
        chkf("fb_body", b_out[0], mk(16'h9999, 1'b1, 1'b1));
        tick();
        b_in = mk(16'h0013, 1'b1, 1'b1);
        tick();
        b_in = '0;
        #1;
        chkf("fb_p3_hdr", b_out[3], mk(16'h0013, 1'b1, 1'b1));
        chkw("fb_p3_v0", 32'(b_out[0].valid), 32'd0);
        tick();
        chkw("fb_drop", 32'(b_drop), 32'd0);
        chkw("fb_rdy", 32'(b_in_ready), 32'd1);

        // Drop counter saturation: 65537 back-to-back single-flit unknown packets
        a_in = mk(16'h0005, 1'b1, 1'b1);
        repeat (65534) tick();
        chkw("sat_fffe", 32'(a_drop), 32'h0000_FFFE);
        tick();
        chkw("sat_ffff", 32'(a_drop), 32'h0000_FFFF);
        tick();
        tick();
        chkw("sat_hold", 32'(a_drop), 32'h0000_FFFF);
        chkw("sat_state", 32'(a_state), 32'd0);
        chkw("sat_v0", 32'(a_out[0].valid), 32'd0);
        a_in = '0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/osd_dii_demux.md
# osd_dii_demux

Packet demultiplexer that sits directly downstream of the host interface module's ingress path (GLIP to DII). It consumes the DII packet stream the host interface emits and steers each complete packet to one of `PORTS` DII outputs, using the destination ID carried in the packet's first flit. Packets addressed outside the configured ID window are either dropped and counted, or sent to port 0. Packets are never interleaved.

## Interface
- `PORTS`, 2: number of DII outputs; legal range 2..16.
- `BASE_ID`, 16'h0000: destination ID that maps to port 0; port i owns ID `BASE_ID + i`.
- `DROP_UNKNOWN`, 1: 1 = drop and count out-of-window packets; 0 = route them to port 0.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `dii_in`  in  dii_flit  incoming flit: `data[15:0]`, `valid`, `last`.
- `dii_in_ready`  out  1  flit on `dii_in` is accepted when `valid & ready`.
- `dii_out[PORTS]`  out  dii_flit  per-port outgoing flit.
- `dii_out_ready[PORTS]`  in  1  per-port sink ready.
- `drop_count`  out  16  count of dropped packets; saturating.

## Operation
- Flit 0 of a packet is the header; `data[15:0]` is the destination ID.
- Routing arithmetic, 16-bit unsigned with no wrap:
  - In window when `dest >= BASE_ID` and `dest - BASE_ID < PORTS`; then `sel = dest - BASE_ID`.
  - Otherwise: drop if `DROP_UNKNOWN=1`, else `sel = 0`.
  - Elaboration check: `BASE_ID + PORTS - 1 <= 16'hFFFF`.
- FSM states: IDLE, HDR, FWD, DROP.
- IDLE
  - `dii_in_ready=1`; all `dii_out[*].valid=0`.
  - On accepting a header, capture flit and `sel` into the header register.
  - Routed header: go to HDR.
  - Dropped header: increment `drop_count`. Go to DROP if `last=0`; stay in IDLE if `last=1`.
- HDR
  - `dii_out[sel]` is driven from the header register, valid=1; `dii_in_ready=0`.
  - When `dii_out_ready[sel]=1`: go to IDLE if header `last=1`, else go to FWD.
- FWD
  - `dii_out[sel] = dii_in` combinationally (data, valid, last).
  - `dii_in_ready = dii_out_ready[sel]`.
  - Accepting a flit with `last=1` returns to IDLE.
- DROP
  - `dii_in_ready=1`; no output is valid; flits are discarded.
  - Accepting a flit with `last=1` returns to IDLE.
- Unselected ports: `valid=0` always; their `data` and `last` are driven 0.
- `drop_count` increments at header acceptance only, and holds at 16'hFFFF.
- Packet lengths are not checked. A missing `last` keeps the FSM in FWD or DROP indefinitely.

## Timing
- Reset asserted (`rst=0`), effective immediately and asynchronously:
  - FSM goes to IDLE; `drop_count=0`; header register cleared.
  - All `dii_out[*].valid=0`.
  - `dii_in_ready=0` while `rst=0`, gated combinationally.
- First cycle after reset release: `dii_in_ready=1`.
- Reset mid-packet discards the remaining state. Downstream sees a truncated packet; no recovery is attempted.
- Header latency: accepted in cycle N, presented on `dii_out[sel]` in cycle N+1 (registered).
- Body flits: zero latency, combinational pass-through in FWD.
- Throughput: one bubble per packet (the IDLE acceptance cycle). Best case is an L-flit packet every L+1 cycles.
- Output valid must hold with stable data until ready:
  - HDR guarantees this from the header register.
  - FWD inherits it from the upstream DII valid/ready rule.
- No combinational path from `dii_out_ready` to `dii_out.valid`.
- Combinational paths that exist:
  - FWD: `dii_in` to `dii_out`.
  - FWD: `dii_out_ready[sel]` to `dii_in_ready`.

## Test plan
- Routing to port 1: `BASE_ID=16'h0010`, `PORTS=2`; send 3-flit packet {0011, AAAA, BBBB(last)} with all sinks ready -> port 1 receives all 3 flits in order, port 0 nothing, `drop_count=0`; next packet header accepted in cycle 4.
- Single-flit packet: header 0010 with `last=1` -> port 0 gets one flit with `last=1`; FSM back in IDLE in the following cycle.
- Drop path, `DROP_UNKNOWN=1`: 4-flit packet to 0005, then 2-flit packet to 0010 -> first packet consumed with no output valid and `drop_count=1`; second packet delivered to port 0.
- Drop saturation and fallback:
  - 65537 single-flit unknown packets -> `drop_count` saturates at 16'hFFFF.
  - With `DROP_UNKNOWN=0`, header 0005 is routed to port 0 and `drop_count` stays 0.
- Backpressure: hold `dii_out_ready[1]=0` for 5 cycles during HDR, then toggle it every cycle during FWD -> header held stable and no flit lost or duplicated; `dii_in_ready` mirrors `dii_out_ready[1]` in FWD.
- Async reset mid-packet: assert `rst=0` between clock edges during FWD of a 4-flit packet -> all valid=0 and `dii_in_ready=0` immediately; after release, a fresh 2-flit packet routes correctly.
